// File: rtl/boid_pkg.sv
// Shared types and defaults for the boid memory arbiter.
// The optional starvation guard is enabled by defining BOID_ARB_STARVE_EN.
package boid_pkg;

   localparam int BOID_ADDR_W = 12;
   localparam int BOID_DATA_W = 32;
   localparam int BOID_LEN_W  = 8;

   // 32-bit words per boid record in the data RAM
   localparam int BOID_REC_STRIDE = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/boid_arb_return.sv
// One-cycle return pipeline: a VGA issue in cycle N yields vga_rvalid,
// vga_rdata and vga_rindex in cycle N+1, aligned with the RAM read latency.
module boid_arb_return
   import boid_pkg::*;
#(
   parameter int DATA_W = BOID_DATA_W,
   parameter int LEN_W  = BOID_LEN_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              issue,
   input  logic [LEN_W-1:0]  issue_idx,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic [LEN_W-1:0]  vga_rindex
);

   logic             tag_q;
   logic [LEN_W-1:0] idx_q;

   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tag_q <= 1'b0;
         idx_q <= '0;
      end else begin
         tag_q <= issue;
         if (issue)
            idx_q <= issue_idx;
      end
   end

   assign vga_rvalid = tag_q;
   assign vga_rindex = idx_q;
   // RAM data is passed through only when it belongs to a VGA issue
   assign vga_rdata  = tag_q ? ram_rdata : '0;

endmodule

// File: rtl/boid_mem_arbiter.sv
// Shares the processor data RAM between the CPU port (always first) and a
// VGA boid-record burst reader. BOID_ARB_STARVE_EN adds the cpu_stall guard.
module boid_mem_arbiter
   import boid_pkg::*;
#(
   parameter int ADDR_W = BOID_ADDR_W,
   parameter int DATA_W = BOID_DATA_W,
   parameter int LEN_W  = BOID_LEN_W
`ifdef BOID_ARB_STARVE_EN
  ,parameter int STARVE_MAX = 16
`endif
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cpu_wren,
   input  logic              cpu_rden,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
`ifdef BOID_ARB_STARVE_EN
   output logic              cpu_stall,
`endif
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_base,
   input  logic [LEN_W-1:0]  vga_len,
   output logic              vga_busy,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic [LEN_W-1:0]  vga_rindex,
   output logic              vga_done,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx_q;
   logic              cpu_access;
   logic              cpu_grant;
   logic              issue;
   logic              last_issue;
   logic [ADDR_W-1:0] issue_addr;

   assign cpu_access = cpu_wren | cpu_rden;

`ifdef BOID_ARB_STARVE_EN
   localparam int STARVE_W = $clog2(STARVE_MAX + 1);

   logic [STARVE_W-1:0] starve_q;

   // Counts consecutive BURST cycles lost to the CPU; saturation forces one VGA slot
   assign cpu_stall = (state_q == BURST) && (starve_q == STARVE_W'(STARVE_MAX));
   assign cpu_grant = cpu_access & ~cpu_stall;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         starve_q <= '0;
      else if (issue || state_q != BURST)
         starve_q <= '0;
      else if (cpu_access)
         starve_q <= starve_q + STARVE_W'(1);
   end
`else
   assign cpu_grant = cpu_access;
`endif

   assign issue      = (state_q == BURST) && !cpu_grant;
   assign issue_addr = base_q + ADDR_W'(idx_q);
   assign last_issue = issue && (idx_q == len_q - LEN_W'(1));

   assign cpu_rdata  = ram_rdata;
   assign ram_wdata  = cpu_wdata;
   assign vga_busy   = (state_q != IDLE);

   // Zero-length bursts complete on their first DRAIN cycle without any read
   assign vga_done = (state_q == DRAIN) &&
                     ((len_q == '0) ||
                      (vga_rvalid && vga_rindex == len_q - LEN_W'(1)));

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      ram_wen  = 1'b0;
      ram_addr = addr_q;
      if (cpu_grant) begin
         ram_wen  = cpu_wren;
         ram_addr = cpu_addr;
      end else if (issue) begin
         ram_addr = issue_addr;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (vga_req) state_d = (vga_len == '0) ? DRAIN : BURST;
         BURST:   if (last_issue) state_d = DRAIN;
         DRAIN:   if (vga_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= ram_addr;
         if (state_q == IDLE && vga_req) begin
            base_q <= vga_base;
            len_q  <= vga_len;
            idx_q  <= '0;
         end else if (issue) begin
            idx_q  <= idx_q + LEN_W'(1);
         end
      end
   end

   boid_arb_return #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_return (
      .clock      (clock),
      .resetn     (resetn),
      .issue      (issue),
      .issue_idx  (idx_q),
      .ram_rdata  (ram_rdata),
      .vga_rvalid (vga_rvalid),
      .vga_rdata  (vga_rdata),
      .vga_rindex (vga_rindex)
   );

endmodule

// File: tb/tb_boid_mem_arbiter.sv
// Directed bench for boid_mem_arbiter with a behavioural one-cycle RAM.
// Define BOID_ARB_STARVE_EN to also exercise the starvation guard.
module tb_boid_mem_arbiter;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic        cpu_wren = 1'b0;
   logic        cpu_rden = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        vga_req = 1'b0;
   logic [11:0] vga_base = '0;
   logic [7:0]  vga_len = '0;
   logic        vga_busy;
   logic        vga_rvalid;
   logic [31:0] vga_rdata;
   logic [7:0]  vga_rindex;
   logic        vga_done;
   logic        ram_wen;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
`ifdef BOID_ARB_STARVE_EN
   logic        cpu_stall;
`endif

   logic [31:0] mem [0:4095];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (ram_wen)
         mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   boid_mem_arbiter dut (
      .clock      (clock),
      .resetn     (resetn),
      .cpu_wren   (cpu_wren),
      .cpu_rden   (cpu_rden),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
`ifdef BOID_ARB_STARVE_EN
      .cpu_stall  (cpu_stall),
`endif
      .vga_req    (vga_req),
      .vga_base   (vga_base),
      .vga_len    (vga_len),
      .vga_busy   (vga_busy),
      .vga_rvalid (vga_rvalid),
      .vga_rdata  (vga_rdata),
      .vga_rindex (vga_rindex),
      .vga_done   (vga_done),
      .ram_wen    (ram_wen),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
      cpu_wren  = 1'b1;
      cpu_addr  = a;
      cpu_wdata = d;
      tick();
      cpu_wren  = 1'b0;
   endtask

   // Leaves the bench at the start of cycle 1 (just after the sampling edge 0)
   task automatic start_burst(input logic [11:0] b, input logic [7:0] l);
      vga_req  = 1'b1;
      vga_base = b;
      vga_len  = l;
      tick();
      vga_req  = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #2 resetn = 1'b0;
      #3;
      n_total++;
      if ({ram_wen, ram_addr, vga_busy, vga_rvalid, vga_rdata, vga_rindex, vga_done} !== '0)
         $display("FAIL reset_outputs: wen=%b addr=%h busy=%b rv=%b rdata=%h ridx=%h done=%b, all required 0",
                  ram_wen, ram_addr, vga_busy, vga_rvalid, vga_rdata, vga_rindex, vga_done);
      else
         n_pass++;
`ifdef BOID_ARB_STARVE_EN
      n_total++;
      if (cpu_stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", cpu_stall);
      else n_pass++;
`endif
      repeat (2) @(posedge clock);
      @(negedge clock) resetn = 1'b1;
      tick();
   endtask

   task automatic preload();
      for (int i = 0; i < 4; i++) cpu_write(12'h100 + 12'(i), 32'hA0 + i);
      for (int i = 0; i < 3; i++) cpu_write(12'h200 + 12'(i), 32'hB0 + i);
      cpu_write(12'h010, 32'hC0);
      cpu_write(12'h011, 32'hC1);
      cpu_write(12'hFFE, 32'hD0);
      cpu_write(12'hFFF, 32'hD1);
      cpu_write(12'h000, 32'hD2);
      tick();
   endtask

   task automatic test_uncontended();
      logic exp_rv, exp_done, exp_busy;
      start_burst(12'h100, 8'd4);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         exp_rv   = (c >= 2 && c <= 5);
         exp_done = (c == 5);
         exp_busy = (c <= 5);
         n_total++;
         if ({vga_rvalid, vga_done, vga_busy} !== {exp_rv, exp_done, exp_busy})
            $display("FAIL uncont_ctrl c%0d: rv/done/busy=%b%b%b required %b%b%b",
                     c, vga_rvalid, vga_done, vga_busy, exp_rv, exp_done, exp_busy);
         else n_pass++;
         if (exp_rv) begin
            n_total++;
            if (vga_rindex !== 8'(c - 2) || vga_rdata !== 32'hA0 + 32'(c - 2))
               $display("FAIL uncont_data c%0d: idx=%0d data=%h required idx=%0d data=%h",
                        c, vga_rindex, vga_rdata, c - 2, 32'hA0 + 32'(c - 2));
            else n_pass++;
         end
         if (c == 1) begin
            n_total++;
            if (ram_addr !== 12'h100 || ram_wen !== 1'b0)
               $display("FAIL uncont_addr: addr=%h wen=%b required 100/0", ram_addr, ram_wen);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_contended();
      logic       exp_rv, exp_done, exp_busy;
      logic [7:0] exp_idx;
      start_burst(12'h200, 8'd3);
      for (int c = 1; c <= 7; c++) begin
         cpu_rden = (c == 2 || c == 3);
         cpu_addr = (c == 2) ? 12'h010 : 12'h011;
         @(negedge clock);
         exp_rv   = (c == 2 || c == 5 || c == 6);
         exp_idx  = (c == 2) ? 8'd0 : (c == 5) ? 8'd1 : 8'd2;
         exp_done = (c == 6);
         exp_busy = (c <= 6);
         n_total++;
         if ({vga_rvalid, vga_done, vga_busy} !== {exp_rv, exp_done, exp_busy})
            $display("FAIL cont_ctrl c%0d: rv/done/busy=%b%b%b required %b%b%b",
                     c, vga_rvalid, vga_done, vga_busy, exp_rv, exp_done, exp_busy);
         else n_pass++;
         if (exp_rv) begin
            n_total++;
            if (vga_rindex !== exp_idx || vga_rdata !== 32'hB0 + 32'(exp_idx))
               $display("FAIL cont_data c%0d: idx=%0d data=%h required idx=%0d data=%h",
                        c, vga_rindex, vga_rdata, exp_idx, 32'hB0 + 32'(exp_idx));
            else n_pass++;
         end
         if (c == 2) begin
            n_total++;
            if (ram_addr !== 12'h010 || ram_wen !== 1'b0)
               $display("FAIL cont_cpu_addr: addr=%h wen=%b required 010/0", ram_addr, ram_wen);
            else n_pass++;
         end
         if (c == 3 || c == 4) begin
            n_total++;
            if (cpu_rdata !== ((c == 3) ? 32'hC0 : 32'hC1))
               $display("FAIL cont_cpu_rdata c%0d: got %h required %h",
                        c, cpu_rdata, (c == 3) ? 32'hC0 : 32'hC1);
            else n_pass++;
         end
         tick();
      end
      cpu_rden = 1'b0;
   endtask

   task automatic test_wrap_and_zero();
      logic [11:0] exp_addr;
      logic        exp_rv;
      start_burst(12'hFFE, 8'd3);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clock);
         if (c <= 3) begin
            exp_addr = (c == 1) ? 12'hFFE : (c == 2) ? 12'hFFF : 12'h000;
            n_total++;
            if (ram_addr !== exp_addr)
               $display("FAIL wrap_addr c%0d: got %h required %h", c, ram_addr, exp_addr);
            else n_pass++;
         end
         exp_rv = (c >= 2 && c <= 4);
         n_total++;
         if ({vga_rvalid, vga_done, vga_busy} !== {exp_rv, c == 4, c <= 4})
            $display("FAIL wrap_ctrl c%0d: rv/done/busy=%b%b%b required %b%b%b",
                     c, vga_rvalid, vga_done, vga_busy, exp_rv, c == 4, c <= 4);
         else n_pass++;
         if (exp_rv) begin
            n_total++;
            if (vga_rindex !== 8'(c - 2) || vga_rdata !== 32'hD0 + 32'(c - 2))
               $display("FAIL wrap_data c%0d: idx=%0d data=%h required idx=%0d data=%h",
                        c, vga_rindex, vga_rdata, c - 2, 32'hD0 + 32'(c - 2));
            else n_pass++;
         end
         tick();
      end

      start_burst(12'h050, 8'd0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         n_total++;
         if ({vga_rvalid, vga_done, vga_busy} !== {1'b0, c == 1, c == 1})
            $display("FAIL zero_len c%0d: rv/done/busy=%b%b%b required 0%b%b",
                     c, vga_rvalid, vga_done, vga_busy, c == 1, c == 1);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_simultaneous_store();
      start_burst(12'h100, 8'd1);
      cpu_wren  = 1'b1;
      cpu_addr  = 12'h100;
      cpu_wdata = 32'h1234_5678;
      @(negedge clock);
      n_total++;
      if (ram_wen !== 1'b1 || ram_addr !== 12'h100 || ram_wdata !== 32'h1234_5678)
         $display("FAIL store_bus: wen=%b addr=%h wdata=%h required 1/100/12345678",
                  ram_wen, ram_addr, ram_wdata);
      else n_pass++;
      tick();
      cpu_wren = 1'b0;
      @(negedge clock);
      n_total++;
      if (ram_wen !== 1'b0 || ram_addr !== 12'h100 || vga_rvalid !== 1'b0)
         $display("FAIL store_slip: wen=%b addr=%h rv=%b required 0/100/0",
                  ram_wen, ram_addr, vga_rvalid);
      else n_pass++;
      tick();
      @(negedge clock);
      n_total++;
      if ({vga_rvalid, vga_done, vga_rindex, vga_rdata} !== {1'b1, 1'b1, 8'd0, 32'h1234_5678})
         $display("FAIL store_return: rv=%b done=%b idx=%0d data=%h required 1/1/0/12345678",
                  vga_rvalid, vga_done, vga_rindex, vga_rdata);
      else n_pass++;
      tick();
      @(negedge clock);
      n_total++;
      if (vga_busy !== 1'b0) $display("FAIL store_idle: busy=%b required 0", vga_busy);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid_burst();
      logic exp_rv;
      int   seen_done;
      start_burst(12'h300, 8'd8);
      tick();
      tick();
      resetn = 1'b0;
      #1;
      n_total++;
      if ({ram_wen, ram_addr, vga_busy, vga_rvalid, vga_rdata, vga_rindex, vga_done} !== '0)
         $display("FAIL midrst_outputs: wen=%b addr=%h busy=%b rv=%b rdata=%h ridx=%h done=%b, all required 0",
                  ram_wen, ram_addr, vga_busy, vga_rvalid, vga_rdata, vga_rindex, vga_done);
      else n_pass++;
      @(posedge clock);
      @(negedge clock) resetn = 1'b1;
      tick();
      seen_done = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (vga_done || vga_rvalid || vga_busy) seen_done++;
         tick();
      end
      n_total++;
      if (seen_done != 0)
         $display("FAIL midrst_quiet: %0d cycles with activity, required 0", seen_done);
      else n_pass++;

      start_burst(12'h100, 8'd2);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clock);
         exp_rv = (c == 2 || c == 3);
         n_total++;
         if ({vga_rvalid, vga_done, vga_busy} !== {exp_rv, c == 3, c <= 3})
            $display("FAIL midrst_again c%0d: rv/done/busy=%b%b%b required %b%b%b",
                     c, vga_rvalid, vga_done, vga_busy, exp_rv, c == 3, c <= 3);
         else n_pass++;
         if (c == 3) begin
            n_total++;
            if (vga_rindex !== 8'd1 || vga_rdata !== 32'hA1)
               $display("FAIL midrst_data: idx=%0d data=%h required 1/a1", vga_rindex, vga_rdata);
            else n_pass++;
         end
         tick();
      end
   endtask

`ifdef BOID_ARB_STARVE_EN
   task automatic test_starvation();
      logic exp_rv;
      cpu_rden = 1'b1;
      cpu_addr = 12'h010;
      start_burst(12'h200, 8'd2);
      for (int c = 1; c <= 21; c++) begin
         cpu_rden = (c <= 18);
         @(negedge clock);
         exp_rv = (c == 18 || c == 20);
         n_total++;
         if ({cpu_stall, vga_rvalid, vga_done, vga_busy} !== {c == 17, exp_rv, c == 20, c <= 20})
            $display("FAIL starve_ctrl c%0d: stall/rv/done/busy=%b%b%b%b required %b%b%b%b",
                     c, cpu_stall, vga_rvalid, vga_done, vga_busy, c == 17, exp_rv, c == 20, c <= 20);
         else n_pass++;
         if (c == 17) begin
            n_total++;
            if (ram_addr !== 12'h200 || ram_wen !== 1'b0)
               $display("FAIL starve_issue: addr=%h wen=%b required 200/0", ram_addr, ram_wen);
            else n_pass++;
         end
         if (exp_rv) begin
            n_total++;
            if (vga_rindex !== ((c == 18) ? 8'd0 : 8'd1) ||
                vga_rdata !== ((c == 18) ? 32'hB0 : 32'hB1))
               $display("FAIL starve_data c%0d: idx=%0d data=%h", c, vga_rindex, vga_rdata);
            else n_pass++;
         end
         tick();
      end
      cpu_rden = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      preload();
      test_uncontended();
      test_contended();
      test_wrap_and_zero();
      test_simultaneous_store();
      test_reset_mid_burst();
`ifdef BOID_ARB_STARVE_EN
      test_starvation();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
